// File: rtl/apb_axi_bridge.sv
// APB completer to single-beat AXI master bridge; one transaction in flight,
// the APB access phase is stretched with p_ready until the AXI response returns.
module apb_axi_bridge #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 a_clk,
    input  logic                 a_reset_n,
    input  logic                 p_clk_en,
    input  logic [AddrWidth-1:0] p_addr,
    input  logic                 p_sel,
    input  logic                 p_enable,
    input  logic                 p_write,
    input  logic [DataWidth-1:0] p_wdata,
    output logic [DataWidth-1:0] p_rdata,
    output logic                 p_ready,
    output logic                 p_slverr,
    output logic                 aw_valid,
    input  logic                 aw_ready,
    output logic [AddrWidth-1:0] aw_addr,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [DataWidth-1:0] w_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [1:0]           b_resp,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [AddrWidth-1:0] ar_addr,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DataWidth-1:0] r_data,
    input  logic [1:0]           r_resp
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 aw_pend_q, aw_pend_d;
    logic                 w_pend_q, w_pend_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 slverr_q, slverr_d;

    // Only resp[1] distinguishes error responses from OKAY/EXOKAY.
    logic unused_resp;
    assign unused_resp = b_resp[0] ^ r_resp[0];

    always_ff @(posedge a_clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        unique case (state_q)
            IDLE: begin
                if (p_clk_en && p_sel && !p_enable) begin
                    state_d   = REQ;
                    addr_d    = p_addr;
                    wdata_d   = p_wdata;
                    write_d   = p_write;
                    aw_pend_d = p_write;
                    w_pend_d  = p_write;
                end
            end
            REQ: begin
                if (write_q) begin
                    // aw and w complete independently; leave once neither is pending.
                    aw_pend_d = aw_pend_q && !aw_ready;
                    w_pend_d  = w_pend_q && !w_ready;
                    if (!aw_pend_d && !w_pend_d) state_d = RESP;
                end else if (ar_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (write_q && b_valid) begin
                    state_d  = DONE;
                    slverr_d = b_resp[1];
                    rdata_d  = '0;
                end else if (!write_q && r_valid) begin
                    state_d  = DONE;
                    slverr_d = r_resp[1];
                    rdata_d  = r_data;
                end
            end
            DONE: begin
                if (p_clk_en && p_sel && p_enable) begin
                    state_d  = IDLE;
                    slverr_d = 1'b0;
                end else if (p_clk_en && !p_sel) begin
                    state_d  = IDLE;
                    slverr_d = 1'b0;
                    rdata_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aw_valid = (state_q == REQ) && write_q && aw_pend_q;
        w_valid  = (state_q == REQ) && write_q && w_pend_q;
        ar_valid = (state_q == REQ) && !write_q;
        b_ready  = (state_q == RESP) && write_q;
        r_ready  = (state_q == RESP) && !write_q;
        p_ready  = (state_q == DONE);
        p_slverr = slverr_q;
        p_rdata  = rdata_q;
        aw_addr  = addr_q;
        ar_addr  = addr_q;
        w_data   = wdata_q;
    end

endmodule
